// File: rtl/mult_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_ctrl_pkg
//  Purpose  : Shared types, widths and per-step operand/shift selection for
//             the sequential 8x8 multiply controller.
//  Revision : 1.0 - initial release
// ============================================================================
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRI  = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int STEP_W      = 2;
    localparam int FAULT_CNT_W = 8;
    localparam int ACC_W       = 16;

    // Left shift applied to each step's partial product
    localparam logic [3:0] SHIFT0 = 4'd0;
    localparam logic [3:0] SHIFT1 = 4'd4;
    localparam logic [3:0] SHIFT2 = 4'd4;
    localparam logic [3:0] SHIFT3 = 4'd8;

    // Nibble select per step (bit index = step): 1 selects the high nibble.
    // Steps 2,3 use AH; steps 1,3 use BH.
    localparam logic [3:0] SEL_A_HI = 4'b1100;
    localparam logic [3:0] SEL_B_HI = 4'b1010;

    function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
        logic [3:0] sh;
        case (step)
            2'd0:    sh = SHIFT0;
            2'd1:    sh = SHIFT1;
            2'd2:    sh = SHIFT2;
            default: sh = SHIFT3;
        endcase
        return sh;
    endfunction

    // Returns {x, y}: the primary-pass operands of the given step
    function automatic logic [7:0] step_operands(input logic [STEP_W-1:0] step,
                                                 input logic [7:0]        a,
                                                 input logic [7:0]        b);
        logic [3:0] x;
        logic [3:0] y;
        x = SEL_A_HI[step] ? a[7:4] : a[3:0];
        y = SEL_B_HI[step] ? b[7:4] : b[3:0];
        return {x, y};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult8_pp_accum.sv
`default_nettype none
// ============================================================================
//  Module   : mult8_pp_accum
//  Purpose  : 16-bit shift-and-add accumulator for 4x4 partial products.
//             'sum' is the value the accumulator will hold after an add, so
//             the controller can capture the final product in the same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module mult8_pp_accum
    import mult_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             add,
    input  logic [7:0]       pp,
    input  logic [3:0]       shift,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] acc;

    assign sum = acc + (ACC_W'(pp) << shift);

    // Accumulator register: clear wins over add, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult8_seq_ctrl
//  Purpose  : Builds an 8x8 unsigned multiply from four passes through an
//             external shared 4x4 core, optionally re-running each pass with
//             swapped operands to catch transient core faults.
//  Revision : 1.0 - initial release
// ============================================================================
module mult8_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int RECHECK   = 1,
    parameter int MAX_RETRY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             a,
    input  logic [7:0]             b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            product,
    output logic                   fault,
    output logic [FAULT_CNT_W-1:0] fault_cnt,
    output logic [3:0]             mul_a,
    output logic [3:0]             mul_b,
    input  logic [7:0]             mul_p
);

    localparam logic       RECHECK_EN  = (RECHECK != 0);
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

    state_t            state;
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic [7:0]        p_pri;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_inc;
    logic [1:0]        retry;
    logic              fault_flag;

    logic              accept;
    logic              chk_match;
    logic              retry_left;
    logic              pass_done;
    logic              last_step;
    logic              txn_fault;
    logic [7:0]        pp;
    logic [3:0]        shift;
    logic [7:0]        ops_next;
    logic [ACC_W-1:0]  sum;

    assign accept     = (state == IDLE) && in_ready && in_valid;
    assign chk_match  = (mul_p == p_pri);
    assign retry_left = (retry < RETRY_LIMIT);
    // A step is final after a single-pass PRI, or a CHK that either agrees
    // or has used up its retries (the primary result is kept in that case).
    assign pass_done  = ((state == PRI) && !RECHECK_EN) ||
                        ((state == CHK) && (chk_match || !retry_left));
    assign txn_fault  = fault_flag || ((state == CHK) && !chk_match);
    assign pp         = (state == PRI) ? mul_p : p_pri;
    assign shift      = step_shift(step);
    assign last_step  = (step == STEP_W'(3));
    assign step_inc   = step + STEP_W'(1);
    assign ops_next   = step_operands(step_inc, a_q, b_q);

    mult8_pp_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .add   (pass_done),
        .pp    (pp),
        .shift (shift),
        .sum   (sum)
    );

    // Sequencer: state, step/retry bookkeeping and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            product    <= '0;
            fault      <= 1'b0;
            fault_cnt  <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            p_pri      <= '0;
            step       <= '0;
            retry      <= '0;
            fault_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q            <= a;
                        b_q            <= b;
                        fault_flag     <= 1'b0;
                        step           <= '0;
                        retry          <= '0;
                        in_ready       <= 1'b0;
                        {mul_a, mul_b} <= step_operands(STEP_W'(0), a, b);
                        state          <= PRI;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                PRI: begin
                    p_pri <= mul_p;
                    if (RECHECK_EN) begin
                        mul_a <= mul_b;
                        mul_b <= mul_a;
                        state <= CHK;
                    end
                end
                CHK: begin
                    if (pass_done) begin
                        retry      <= '0;
                        fault_flag <= txn_fault;
                    end else begin
                        // Mismatch with retries left: redo the primary pass
                        retry <= retry + 2'd1;
                        mul_a <= mul_b;
                        mul_b <= mul_a;
                        state <= PRI;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Step completion, shared by PRI (single pass) and CHK
            if (pass_done) begin
                if (last_step) begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    product   <= sum;
                    fault     <= txn_fault;
                    mul_a     <= '0;
                    mul_b     <= '0;
                    if (txn_fault && (fault_cnt != {FAULT_CNT_W{1'b1}})) begin
                        fault_cnt <= fault_cnt + 8'd1;
                    end
                end else begin
                    step           <= step_inc;
                    {mul_a, mul_b} <= ops_next;
                    state          <= PRI;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult8_seq_ctrl
//  Purpose  : Self-checking bench for mult8_seq_ctrl with a behavioural core
//             model that can inject faults by cycle position.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult8_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance with recheck (MAX_RETRY=1)
    logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_fault;
    logic [7:0]  d1_a, d1_b, d1_fault_cnt, d1_mul_p;
    logic [15:0] d1_product;
    logic [3:0]  d1_mul_a, d1_mul_b;
    // Single-pass instance
    logic        d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready, d0_fault;
    logic [7:0]  d0_a, d0_b, d0_fault_cnt, d0_mul_p;
    logic [15:0] d0_product;
    logic [3:0]  d0_mul_a, d0_mul_b;

    mult8_seq_ctrl #(.RECHECK(1), .MAX_RETRY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .product(d1_product), .fault(d1_fault), .fault_cnt(d1_fault_cnt),
        .mul_a(d1_mul_a), .mul_b(d1_mul_b), .mul_p(d1_mul_p)
    );

    mult8_seq_ctrl #(.RECHECK(0), .MAX_RETRY(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .a(d0_a), .b(d0_b), .out_valid(d0_out_valid), .out_ready(d0_out_ready),
        .product(d0_product), .fault(d0_fault), .fault_cnt(d0_fault_cnt),
        .mul_a(d0_mul_a), .mul_b(d0_mul_b), .mul_p(d0_mul_p)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;   // cycle index since the accept edge (0 = no transaction)
    int   mode  = 0;   // 0 ideal core, 1 corrupt cycle 3, 2 corrupt every even cycle
    logic cur   = 1'b1;
    int   exp_fcnt1 = 0;
    logic corrupt;

    // 4x4 core models
    always_comb begin
        corrupt = 1'b0;
        if (mode == 1 && cyc == 3) corrupt = 1'b1;
        if (mode == 2 && cyc > 0 && (cyc % 2) == 0) corrupt = 1'b1;
        d1_mul_p = (8'(d1_mul_a) * 8'(d1_mul_b)) ^ {7'd0, corrupt};
        d0_mul_p = 8'(d0_mul_a) * 8'(d0_mul_b);
    end

    logic        c_in_ready, c_out_valid, c_fault;
    logic [15:0] c_product;
    logic [7:0]  c_fault_cnt;
    logic [3:0]  c_mul_a, c_mul_b;
    always_comb begin
        c_in_ready  = cur ? d1_in_ready  : d0_in_ready;
        c_out_valid = cur ? d1_out_valid : d0_out_valid;
        c_fault     = cur ? d1_fault     : d0_fault;
        c_product   = cur ? d1_product   : d0_product;
        c_fault_cnt = cur ? d1_fault_cnt : d0_fault_cnt;
        c_mul_a     = cur ? d1_mul_a     : d0_mul_a;
        c_mul_b     = cur ? d1_mul_b     : d0_mul_b;
    end

    typedef struct {
        logic        sel;
        logic [7:0]  a;
        logic [7:0]  b;
        int          md;
        int          hold;
        logic [15:0] exp_p;
        logic        exp_f;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic ordy);
        if (cur) begin
            d1_in_valid = v; d1_a = av; d1_b = bv; d1_out_ready = ordy;
        end else begin
            d0_in_valid = v; d0_a = av; d0_b = bv; d0_out_ready = ordy;
        end
    endtask

    // Expected primary operands {x, y} of step k
    function automatic logic [7:0] ref_ops(input logic [7:0] av, input logic [7:0] bv, input int k);
        logic [3:0] x;
        logic [3:0] y;
        x = (k >= 2)     ? av[7:4] : av[3:0];
        y = (k % 2 == 1) ? bv[7:4] : bv[3:0];
        return {x, y};
    endfunction

    task automatic run_txn(input logic sel, input logic [7:0] av, input logic [7:0] bv,
                           input int md, input int hold, input logic [15:0] exp_p,
                           input logic exp_f, input int exp_lat);
        int         k;
        logic [7:0] ops;
        cur = sel;
        @(negedge clk);
        check("in_ready_idle", c_in_ready, 1);
        mode = md;
        drive(1'b1, av, bv, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'($urandom), 8'($urandom), 1'b0);
        cyc = 1;
        while (!c_out_valid && cyc < 200) begin
            check("in_ready_busy", c_in_ready, 0);
            if (md == 0) begin
                k   = sel ? (cyc - 1) / 2 : cyc - 1;
                ops = ref_ops(av, bv, k);
                if (sel && (cyc % 2 == 0)) ops = {ops[3:0], ops[7:4]};
                check("core_operands", {c_mul_a, c_mul_b}, ops);
            end
            @(posedge clk); #1;
            cyc++;
        end
        mode = 0;
        if (!c_out_valid) begin
            check("out_valid_timeout", 0, 1);
            cyc = 0;
            return;
        end
        if (sel && exp_f && exp_fcnt1 < 255) exp_fcnt1++;
        check("latency", cyc, exp_lat);
        check("product", c_product, exp_p);
        check("fault", c_fault, exp_f);
        check("fault_cnt", c_fault_cnt, sel ? exp_fcnt1 : 0);
        check("core_quiet", {c_mul_a, c_mul_b}, 0);
        cyc = 0;
        // Back-pressure: result must hold and new requests must be ignored
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive((i % 2) == 0, 8'($urandom), 8'($urandom), 1'b0);
            @(posedge clk); #1;
            check("hold_valid", c_out_valid, 1);
            check("hold_product", c_product, exp_p);
            check("hold_fault", c_fault, exp_f);
            check("hold_in_ready", c_in_ready, 0);
        end
        @(negedge clk);
        drive(1'b0, 8'd0, 8'd0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        check("out_valid_cleared", c_out_valid, 0);
        check("in_ready_after_done", c_in_ready, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  c_in_ready, 0);
        check({tag, "_out_valid"}, c_out_valid, 0);
        check({tag, "_product"},   c_product, 0);
        check({tag, "_fault"},     c_fault, 0);
        check({tag, "_fault_cnt"}, c_fault_cnt, 0);
        check({tag, "_mul_ops"},   {c_mul_a, c_mul_b}, 0);
    endtask

    initial begin
        vec_t        vecs[5];
        logic [7:0]  ra, rb;
        int          rm;

        d1_in_valid = 0; d1_a = 0; d1_b = 0; d1_out_ready = 0;
        d0_in_valid = 0; d0_a = 0; d0_b = 0; d0_out_ready = 0;

        vecs[0] = '{1'b1, 8'h12, 8'h34, 0, 0, 16'h03A8, 1'b0, 9};
        vecs[1] = '{1'b1, 8'hFF, 8'hFF, 0, 5, 16'hFE01, 1'b0, 9};
        vecs[2] = '{1'b1, 8'hAB, 8'hCD, 1, 0, 16'h88EF, 1'b0, 11};
        vecs[3] = '{1'b1, 8'h0F, 8'h0F, 2, 0, 16'h00E1, 1'b1, 17};
        vecs[4] = '{1'b0, 8'h80, 8'h02, 0, 0, 16'h0100, 1'b0, 5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        cur = 1'b1; check_reset_vals("rst1");
        cur = 1'b0; check_reset_vals("rst0");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cur = 1'b1; check("in_ready_release1", c_in_ready, 1);
        cur = 1'b0; check("in_ready_release0", c_in_ready, 1);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].md, vecs[i].hold,
                    vecs[i].exp_p, vecs[i].exp_f, vecs[i].exp_lat);
        end

        // Randomized traffic against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 2 == 0) begin
                rm = int'($urandom_range(0, 2));
                run_txn(1'b1, ra, rb, rm, int'($urandom_range(0, 3)), 16'(ra) * 16'(rb),
                        rm == 2, 9 + 2 * (rm == 1 ? 1 : (rm == 2 ? 4 : 0)));
            end else begin
                run_txn(1'b0, ra, rb, 0, int'($urandom_range(0, 3)), 16'(ra) * 16'(rb), 1'b0, 5);
            end
        end

        // Saturation of the faulty-transaction counter
        for (int i = 0; i < 300; i++) begin
            run_txn(1'b1, 8'h0F, 8'h0F, 2, 0, 16'h00E1, 1'b1, 17);
        end
        cur = 1'b1;
        check("fault_cnt_saturated", c_fault_cnt, 255);

        // Reset asserted during step 2 aborts the transaction
        cur = 1'b1;
        @(negedge clk);
        drive(1'b1, 8'h12, 8'h34, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        check("mid_ops_step2", {c_mul_a, c_mul_b}, 8'h14);
        rst_n = 1'b0;
        #1;
        exp_fcnt1 = 0;
        check_reset_vals("midrst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_midrst", c_in_ready, 1);
        check("no_result_after_midrst", c_out_valid, 0);
        run_txn(1'b1, 8'h03, 8'h05, 0, 0, 16'h000F, 1'b0, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
